// File: rtl/as_watchdog.sv
// Heartbeat supervisor: times the gap between Heartbeat toggles and holds Watchdog
// high only while beats arrive inside [MIN_PERIOD_CYCLES, TIMEOUT_CYCLES]; faults latch.
module as_watchdog #(
   parameter int TIMEOUT_CYCLES    = 100000,
   parameter int MIN_PERIOD_CYCLES = 1000,
   parameter int GRACE_CYCLES      = 2000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       Heartbeat,
   input  logic       Power_on_Reset,
   input  logic       Watchdog_clear,
   output logic       Watchdog,
   output logic [1:0] Wd_state,
   output logic [1:0] Wd_fault_code
);

   localparam int MAX_CYC = (TIMEOUT_CYCLES > GRACE_CYCLES) ? TIMEOUT_CYCLES : GRACE_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   localparam logic [CNT_W-1:0] TIMEOUT_M1  = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_MAX = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] MIN_M1      = CNT_W'(MIN_PERIOD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GRACE_M1    = CNT_W'(GRACE_CYCLES - 1);
   localparam logic [CNT_W-1:0] GRACE_MAX   = CNT_W'(GRACE_CYCLES);

   typedef enum logic [1:0] {
      ST_INIT    = 2'b00,
      ST_ARMED   = 2'b01,
      ST_TRIPPED = 2'b10
   } state_t;

   localparam logic [1:0] FC_NONE     = 2'b00;
   localparam logic [1:0] FC_TIMEOUT  = 2'b01;
   localparam logic [1:0] FC_FAST     = 2'b10;
   localparam logic [1:0] FC_NO_FIRST = 2'b11;

   logic             r_s1;
   logic             r_s2;
   logic             r_s3;
   logic             w_beat;
   state_t           r_state;
   logic [CNT_W-1:0] r_gap;
   logic [CNT_W-1:0] r_grace;
   logic [1:0]       r_code;
   logic             r_watchdog;

   // Synchronizer runs through POR so a toggle during POR is absorbed, not replayed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= Heartbeat;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign w_beat = r_s2 ^ r_s3;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_INIT;
         r_gap      <= '0;
         r_grace    <= '0;
         r_code     <= FC_NONE;
         r_watchdog <= 1'b0;
      end else if (Power_on_Reset) begin
         r_state    <= ST_INIT;
         r_gap      <= '0;
         r_grace    <= '0;
         r_code     <= FC_NONE;
         r_watchdog <= 1'b0;
      end else begin
         r_watchdog <= 1'b0;
         case (r_state)
            ST_INIT: begin
               if (w_beat) begin
                  r_state    <= ST_ARMED;
                  r_gap      <= '0;
                  r_watchdog <= 1'b1;
               end else if (r_grace == GRACE_M1) begin
                  r_state <= ST_TRIPPED;
                  r_code  <= FC_NO_FIRST;
               end else if (r_grace != GRACE_MAX) begin
                  r_grace <= r_grace + CNT_W'(1);
               end
            end
            ST_ARMED: begin
               // A beat in the timeout cycle is checked first, so it rescues the arm.
               if (w_beat) begin
                  if (r_gap < MIN_M1) begin
                     r_state <= ST_TRIPPED;
                     r_code  <= FC_FAST;
                  end else begin
                     r_gap      <= '0;
                     r_watchdog <= 1'b1;
                  end
               end else if (r_gap == TIMEOUT_M1) begin
                  r_state <= ST_TRIPPED;
                  r_code  <= FC_TIMEOUT;
               end else begin
                  if (r_gap != TIMEOUT_MAX) begin
                     r_gap <= r_gap + CNT_W'(1);
                  end
                  r_watchdog <= 1'b1;
               end
            end
            ST_TRIPPED: begin
               if (Watchdog_clear) begin
                  r_state <= ST_INIT;
                  r_code  <= FC_NONE;
                  r_gap   <= '0;
                  r_grace <= '0;
               end
            end
            default: begin
               r_state <= ST_INIT;
               r_gap   <= '0;
               r_grace <= '0;
               r_code  <= FC_NONE;
            end
         endcase
      end
   end

   assign Watchdog      = r_watchdog;
   assign Wd_state      = r_state;
   assign Wd_fault_code = r_code;

endmodule

// File: tb/tb_as_watchdog.sv
// Directed bench for as_watchdog: the driver schedules expected outputs by cycle,
// a negedge monitor pops and compares them against {Watchdog, Wd_state, Wd_fault_code}.
module tb_as_watchdog;

   localparam int T  = 20;
   localparam int MP = 4;
   localparam int G  = 50;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       hb;
   logic       por;
   logic       clr;
   logic       wd;
   logic [1:0] st;
   logic [1:0] code;

   as_watchdog #(
      .TIMEOUT_CYCLES   (T),
      .MIN_PERIOD_CYCLES(MP),
      .GRACE_CYCLES     (G)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .Heartbeat     (hb),
      .Power_on_Reset(por),
      .Watchdog_clear(clr),
      .Watchdog      (wd),
      .Wd_state      (st),
      .Wd_fault_code (code)
   );

   // clock / cycle counter
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // scoreboard: expected {wd, state, code} at a given posedge count
   logic [4:0] exp_q[$];
   int         at_q[$];
   string      nm_q[$];
   int         n_cmp = 0;
   int         n_bad = 0;

   task automatic expect_at(input int c, input logic w, input logic [1:0] s,
                            input logic [1:0] f, input string n);
      int i;
      i = 0;
      while (i < at_q.size() && at_q[i] <= c) i++;
      at_q.insert(i, c);
      exp_q.insert(i, {w, s, f});
      nm_q.insert(i, n);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // monitor
   always @(negedge clk) begin : monitor
      logic [4:0] e;
      logic [4:0] a;
      while (at_q.size() > 0 && at_q[0] <= cyc) begin
         e = exp_q[0];
         a = {wd, st, code};
         n_cmp++;
         if (at_q[0] < cyc) begin
            n_bad++;
            $display("FAIL %s: check for cycle %0d missed (now %0d)", nm_q[0], at_q[0], cyc);
         end else if (a !== e) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got wd=%0b st=%0d code=%0d, want wd=%0b st=%0d code=%0d",
                     nm_q[0], cyc, a[4], a[3:2], a[1:0], e[4], e[3:2], e[1:0]);
         end
         void'(at_q.pop_front());
         void'(exp_q.pop_front());
         void'(nm_q.pop_front());
      end
   end

   // driver
   int r, be, t, u, p, q;

   initial begin
      rst_n = 1'b0;
      hb    = 1'b0;
      por   = 1'b0;
      clr   = 1'b0;

      // reset and arm
      step(2);
      expect_at(cyc + 1, 0, 2'd0, 2'd0, "rst_hold_a");
      expect_at(cyc + 2, 0, 2'd0, 2'd0, "rst_hold_b");
      step(3);
      rst_n = 1'b1;
      r = cyc;
      expect_at(r + 1, 0, 2'd0, 2'd0, "post_rst");
      step(1);
      hb = ~hb;
      be = cyc + 3;
      expect_at(be - 1, 0, 2'd0, 2'd0, "arm_pre");
      expect_at(be, 1, 2'd1, 2'd0, "arm");

      // steady, period 10, with a clear pulse that must do nothing while armed
      for (int k = 0; k < 20; k++) begin
         step(10);
         hb = ~hb;
         be = cyc + 3;
         expect_at(be - 1, 1, 2'd1, 2'd0, "p10_pre");
         expect_at(be, 1, 2'd1, 2'd0, "p10");
         if (k == 5) begin
            clr = 1'b1;
            expect_at(cyc + 1, 1, 2'd1, 2'd0, "clr_armed");
            step(1);
            clr = 1'b0;
         end
      end

      // steady, period 4 (minimum accepted)
      for (int k = 0; k < 8; k++) begin
         step(MP);
         hb = ~hb;
         be = cyc + 3;
         expect_at(be, 1, 2'd1, 2'd0, "p4");
      end

      // steady, period 20 (beat lands in the timeout cycle)
      for (int k = 0; k < 5; k++) begin
         step(T);
         hb = ~hb;
         be = cyc + 3;
         expect_at(be - 1, 1, 2'd1, 2'd0, "p20_pre");
         expect_at(be, 1, 2'd1, 2'd0, "p20");
      end

      // timeout
      expect_at(be + T - 1, 1, 2'd1, 2'd0, "to_pre");
      expect_at(be + T, 0, 2'd2, 2'd1, "timeout");
      step(T + 5);
      for (int k = 0; k < 10; k++) begin
         hb = ~hb;
         expect_at(cyc + 3, 0, 2'd2, 2'd1, "to_hold");
         step(10);
      end

      // too fast
      clr = 1'b1;
      expect_at(cyc + 1, 0, 2'd0, 2'd0, "clr");
      step(1);
      clr = 1'b0;
      step(3);
      hb = ~hb;
      t = cyc;
      expect_at(t + 3, 1, 2'd1, 2'd0, "fast_arm");
      expect_at(t + 5, 1, 2'd1, 2'd0, "fast_pre");
      expect_at(t + 6, 0, 2'd2, 2'd2, "fast_trip");
      step(3);
      hb = ~hb;
      step(5);

      // clear coinciding with a beat: beat ignored
      hb = ~hb;
      u = cyc;
      expect_at(u + 2, 0, 2'd2, 2'd2, "fast_hold");
      expect_at(u + 3, 0, 2'd0, 2'd0, "clr_beat");
      expect_at(u + 10, 0, 2'd0, 2'd0, "clr_wait");
      step(2);
      clr = 1'b1;
      step(1);
      clr = 1'b0;
      step(10);
      hb = ~hb;
      be = cyc + 3;
      expect_at(be - 1, 0, 2'd0, 2'd0, "rearm_pre");
      expect_at(be, 1, 2'd1, 2'd0, "rearm");

      // POR priority with toggles absorbed, grace restarts at release
      step(8);
      p = cyc;
      por = 1'b1;
      for (int k = 1; k <= 5; k++) expect_at(p + k, 0, 2'd0, 2'd0, "por_hold");
      expect_at(p + 6, 0, 2'd0, 2'd0, "por_rel");
      expect_at(p + 20, 0, 2'd0, 2'd0, "por_no_arm");
      expect_at(p + 5 + G - 1, 0, 2'd0, 2'd0, "por_grace_pre");
      expect_at(p + 5 + G, 0, 2'd2, 2'd3, "por_grace");
      step(1);
      hb = ~hb;
      step(1);
      hb = ~hb;
      step(3);
      por = 1'b0;
      step(G + 5);

      // asynchronous reset, then no first heartbeat
      rst_n = 1'b0;
      q = cyc;
      expect_at(q + 1, 0, 2'd0, 2'd0, "rst_async");
      step(2);
      rst_n = 1'b1;
      r = cyc;
      expect_at(r + G - 1, 0, 2'd0, 2'd0, "grace_pre");
      expect_at(r + G, 0, 2'd2, 2'd3, "grace");
      step(G + 3);

      for (int k = 0; k < 50 && at_q.size() > 0; k++) step(1);
      while (at_q.size() > 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: check for cycle %0d never reached (now %0d)", nm_q[0], at_q[0], cyc);
         void'(at_q.pop_front());
         void'(exp_q.pop_front());
         void'(nm_q.pop_front());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
